immediate_decode_stage: RTL
===========================

IMMEDIATE_DECODE_STAGE -- requirements
Module: immediate_decode_stage

Interface
REQ-001 SHALL have parameter XLEN, default 32, immediate width; legal values 32 or 64 only.
REQ-002 SHALL have parameter AUTO_DECODE, default 0; 1 = derive format from opcode and ignore imm_src.
REQ-003 SHALL have port clk  input  1  single clock, all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port flush  input  1  discard the held result.
REQ-006 SHALL have port in_valid  input  1  instr/imm_src valid.
REQ-007 SHALL have port in_ready  output  1  stage can accept.
REQ-008 SHALL have port instr  input  32  raw instruction word.
REQ-009 SHALL have port imm_src  input  3  explicit format select: 000 none, 001 SH, 010 I, 011 S, 100 B, 101 U, 110 J, 111 Z.
REQ-010 SHALL have port out_valid  output  1  result held.
REQ-011 SHALL have port out_ready  input  1  consumer accepts.
REQ-012 SHALL have port imm  output  XLEN  extended immediate.
REQ-013 SHALL have port fmt  output  3  format used, same encoding as imm_src.
REQ-014 SHALL have port illegal  output  1  AUTO_DECODE found an unrecognised opcode.

Function
REQ-015 Formats (s = instr[31] sign-filled to XLEN): I = s,instr[30:20]; S = s,instr[30:25],instr[11:7]; B = s,instr[7],instr[30:25],instr[11:8],0; U = s,instr[30:12],12'b0; J = s,instr[19:12],instr[20],instr[30:21],0.
REQ-016 SH = zero-extended instr[25:20] when XLEN=64, instr[24:20] when XLEN=32; Z = zero-extended instr[19:15]; none = all zeros.
REQ-017 AUTO_DECODE opcode map: 0000011/1100111 -> I; 0010011 -> SH if funct3 is 001 or 101, else I; 0100011 -> S; 1100011 -> B; 0110111/0010111 -> U; 1101111 -> J; 1110011 -> Z if instr[14]=1, else I; 0110011 -> none; any other opcode -> none with illegal=1.
REQ-018 illegal SHALL be 0 whenever AUTO_DECODE=0.
REQ-019 Single output register stage; transfer in when in_valid and in_ready; transfer out when out_valid and out_ready.
REQ-020 in_ready = !out_valid or out_ready (combinational); latency in->out exactly 1 cycle; full throughput of one per cycle.
REQ-021 While out_valid=1 and out_ready=0, imm, fmt and illegal SHALL hold stable.
REQ-022 Simultaneous output and input transfer in one cycle: the new result replaces the old, out_valid stays 1.
REQ-023 flush=1: out_valid cleared next cycle; any input offered that cycle is dropped; flush takes priority over in_valid.
REQ-024 When out_valid=0, imm, fmt and illegal SHALL read 0.

Reset
REQ-025 rst=1 at a clock edge SHALL clear out_valid, imm, fmt and illegal to 0, overriding flush and in_valid, including mid-stall.
REQ-026 in_ready SHALL be 1 during the first cycle after rst deasserts.

Structure
REQ-027 The format codes (NONE, SH, I, S, B, U, J, Z) and RV32/RV64 opcode constants SHALL be defined in the shared CPU package/header and used by the control unit.
REQ-028 The combinational extractor SHALL be a sub-module immediate_format_mux (instr, fmt -> XLEN imm); the opcode decoder and handshake register reside in the top-level module.

Verification
REQ-029 XLEN=32, AUTO_DECODE=0: imm_src=010, instr=0xFFF00093 -> next cycle out_valid=1, imm=0xFFFFFFFF, fmt=010.
REQ-030 XLEN=32, AUTO_DECODE=1, back-to-back inputs 0xFE000CE3, 0x0100006F, 0x123450B7 -> imm 0xFFFFFFF8, 0x00000010, 0x12345000 on consecutive cycles, fmt 100/110/101.
REQ-031 XLEN=64, AUTO_DECODE=1: instr=0x03F09093 (slli x1,x1,63) -> imm=0x000000000000003F, fmt=001; instr=0x800000B7 -> imm=0xFFFFFFFF80000000.
REQ-032 Stall: out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, imm held constant; out_ready=1 -> held value and the queued input each delivered exactly once, in order.
REQ-033 AUTO_DECODE=1, instr=0x0000007F -> illegal=1, imm=0, fmt=000; flush while stalled -> out_valid=0 next cycle; rst during stall -> all outputs 0.

Source files
------------

// File: rtl/immediate_decode_stage_pkg.sv
// Shared CPU decode definitions: immediate format codes, base opcodes and the
// opcode-to-format classifier used by the control unit.
package immediate_decode_stage_pkg;

  typedef enum logic [2:0] {
    FMT_NONE = 3'b000,
    FMT_SH   = 3'b001,
    FMT_I    = 3'b010,
    FMT_S    = 3'b011,
    FMT_B    = 3'b100,
    FMT_U    = 3'b101,
    FMT_J    = 3'b110,
    FMT_Z    = 3'b111
  } imm_fmt_e;

  typedef struct packed {
    imm_fmt_e fmt;
    logic     illegal;
  } imm_dec_t;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  // Shift-immediates share OP_IMM with the I-type ALU ops; funct3 tells them apart.
  function automatic imm_dec_t decode_opcode(input logic [6:0] opcode,
                                             input logic [2:0] funct3);
    imm_dec_t d;
    d.fmt     = FMT_NONE;
    d.illegal = 1'b0;
    case (opcode)
      OPC_LOAD, OPC_JALR: d.fmt = FMT_I;
      OPC_OP_IMM: begin
        if ((funct3 == 3'b001) || (funct3 == 3'b101)) begin
          d.fmt = FMT_SH;
        end else begin
          d.fmt = FMT_I;
        end
      end
      OPC_STORE:          d.fmt = FMT_S;
      OPC_BRANCH:         d.fmt = FMT_B;
      OPC_LUI, OPC_AUIPC: d.fmt = FMT_U;
      OPC_JAL:            d.fmt = FMT_J;
      OPC_SYSTEM: begin
        if (funct3[2]) begin
          d.fmt = FMT_Z;
        end else begin
          d.fmt = FMT_I;
        end
      end
      OPC_OP:             d.fmt = FMT_NONE;
      default: begin
        d.fmt     = FMT_NONE;
        d.illegal = 1'b1;
      end
    endcase
    return d;
  endfunction

endpackage

// File: rtl/immediate_decode_stage_format_mux.sv
// Combinational immediate extractor: assembles the 32-bit immediate for the
// selected format, then sign-extends it to XLEN.
module immediate_format_mux
  import immediate_decode_stage_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     instr,
  input  imm_fmt_e        fmt,
  output logic [XLEN-1:0] imm
);

  logic [31:0] imm32_s;
  logic        unused_opcode_s;

  assign unused_opcode_s = ^instr[6:0];

  // SH and Z carry a zero top bit, so the common sign extension leaves them zero-extended.
  always_comb begin
    imm32_s = 32'h0000_0000;
    case (fmt)
      FMT_NONE: imm32_s = 32'h0000_0000;
      FMT_SH: begin
        if (XLEN == 64) begin
          imm32_s = {26'b0, instr[25:20]};
        end else begin
          imm32_s = {27'b0, instr[24:20]};
        end
      end
      FMT_I: imm32_s = {{21{instr[31]}}, instr[30:20]};
      FMT_S: imm32_s = {{21{instr[31]}}, instr[30:25], instr[11:7]};
      FMT_B: imm32_s = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
      FMT_U: imm32_s = {instr[31], instr[30:12], 12'b0};
      FMT_J: imm32_s = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
      FMT_Z: imm32_s = {27'b0, instr[19:15]};
      default: imm32_s = 32'h0000_0000;
    endcase
    imm = XLEN'($signed(imm32_s));
  end

endmodule

// File: rtl/immediate_decode_stage.sv
// Immediate decode stage: format selection (explicit or from the opcode),
// extraction, and a single valid/ready output register with flush.
module immediate_decode_stage
  import immediate_decode_stage_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int AUTO_DECODE = 0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     instr,
  input  logic [2:0]      imm_src,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] imm,
  output logic [2:0]      fmt,
  output logic            illegal
);

  imm_dec_t        dec_s;
  imm_fmt_e        fmt_sel_s;
  logic            illegal_sel_s;
  logic [XLEN-1:0] imm_ext_s;

  logic            valid_q, valid_d;
  logic [XLEN-1:0] imm_q, imm_d;
  imm_fmt_e        fmt_q, fmt_d;
  logic            illegal_q, illegal_d;

  // Format select: opcode decode when AUTO_DECODE, otherwise the explicit imm_src.
  always_comb begin
    dec_s = decode_opcode(instr[6:0], instr[14:12]);
    if (AUTO_DECODE != 0) begin
      fmt_sel_s     = dec_s.fmt;
      illegal_sel_s = dec_s.illegal;
    end else begin
      fmt_sel_s     = imm_fmt_e'(imm_src);
      illegal_sel_s = 1'b0;
    end
  end

  immediate_format_mux #(
    .XLEN(XLEN)
  ) u_format_mux (
    .instr(instr),
    .fmt  (fmt_sel_s),
    .imm  (imm_ext_s)
  );

  assign in_ready = !valid_q || out_ready;

  // Output register next state; an empty register always holds zeros.
  always_comb begin
    valid_d   = valid_q;
    imm_d     = imm_q;
    fmt_d     = fmt_q;
    illegal_d = illegal_q;
    if (flush) begin
      valid_d   = 1'b0;
      imm_d     = '0;
      fmt_d     = FMT_NONE;
      illegal_d = 1'b0;
    end else if (in_valid && in_ready) begin
      valid_d   = 1'b1;
      imm_d     = imm_ext_s;
      fmt_d     = fmt_sel_s;
      illegal_d = illegal_sel_s;
    end else if (valid_q && out_ready) begin
      valid_d   = 1'b0;
      imm_d     = '0;
      fmt_d     = FMT_NONE;
      illegal_d = 1'b0;
    end else begin
      valid_d   = valid_q;
      imm_d     = imm_q;
      fmt_d     = fmt_q;
      illegal_d = illegal_q;
    end
  end

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q   <= 1'b0;
      imm_q     <= '0;
      fmt_q     <= FMT_NONE;
      illegal_q <= 1'b0;
    end else begin
      valid_q   <= valid_d;
      imm_q     <= imm_d;
      fmt_q     <= fmt_d;
      illegal_q <= illegal_d;
    end
  end

  assign out_valid = valid_q;
  assign imm       = imm_q;
  assign fmt       = fmt_q;
  assign illegal   = illegal_q;

endmodule
